uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling 8N1 UART receiver feeding a byte FIFO,
// read through a 16-bit data/status register port with an activity LED.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 8,
    parameter int LED_HOLD = 2_500_000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        uart_rx,
    input  logic        cs,
    input  logic        rd,
    input  logic [1:0]  addr,
    output logic [15:0] d_out,
    output logic        rx_avail,
    output logic        rx_led
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = $clog2(LED_HOLD + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_sync;
    logic            r_armed;
    logic [DW-1:0]   r_div;
    logic [3:0]      r_samp;
    logic [1:0]      r_votes;
    logic [2:0]      r_bits;
    logic [7:0]      r_shift;
    logic [AW:0]     r_wptr, r_rptr;
    logic [7:0]      r_mem [DEPTH];
    logic            r_ferr, r_ovr;
    logic [LW-1:0]   r_led_cnt;

    logic w_rx, w_tick, w_mid, w_maj;
    logic w_enter, w_shift, w_push, w_ferr_set;
    logic w_full, w_empty, w_rd, w_pop, w_stat, w_wr, w_ovr_set;
    logic [7:0]  w_head;
    logic [15:0] w_status;

    assign w_rx   = r_sync[1];
    assign w_tick = (r_div == DW'(DIV - 1));
    assign w_mid  = w_tick && (r_samp == 4'd8);
    // r_votes holds samples 7 and 8; the live line is sample 9
    assign w_maj  = (r_votes[1] & r_votes[0]) | (r_votes[1] & w_rx) | (r_votes[0] & w_rx);

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) r_sync <= 2'b11;
        else r_sync <= {r_sync[0], uart_rx};
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_enter    = 1'b0;
        w_shift    = 1'b0;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            IDLE: if (r_armed && !w_rx) begin
                w_next  = START;
                w_enter = 1'b1;
            end
            START: if (w_mid) w_next = w_maj ? IDLE : DATA;
            DATA: if (w_mid) begin
                w_shift = 1'b1;
                if (r_bits == 3'd7) w_next = STOP;
            end
            STOP: if (w_mid) begin
                w_next     = IDLE;
                w_push     = w_maj;
                w_ferr_set = !w_maj;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_armed <= 1'b0;
            r_div   <= '0;
            r_samp  <= '0;
            r_votes <= '0;
            r_bits  <= '0;
            r_shift <= '0;
        end else begin
            if (w_ferr_set) r_armed <= 1'b0;
            else if (r_state == IDLE && w_rx) r_armed <= 1'b1;
            r_div <= (w_enter || w_tick) ? '0 : r_div + 1'b1;
            if (w_enter) r_samp <= '0;
            else if (w_tick) r_samp <= r_samp + 1'b1;
            if (w_tick && (r_samp == 4'd6 || r_samp == 4'd7)) r_votes <= {r_votes[0], w_rx};
            if (w_enter) r_bits <= '0;
            else if (w_shift) r_bits <= r_bits + 1'b1;
            if (w_shift) r_shift <= {w_maj, r_shift[7:1]};
        end
    end

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd      = cs & rd;
    assign w_pop     = w_rd && (addr == 2'd0) && !w_empty;
    assign w_stat    = w_rd && (addr == 2'd1);
    // a pop on the push cycle frees the slot, so a full FIFO still takes the byte
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;
    assign w_head    = r_mem[r_rptr[AW-1:0]];
    assign w_status  = {12'h000, r_ferr, r_ovr, w_full, rx_avail};
    assign rx_avail  = !w_empty;
    assign rx_led    = (r_led_cnt != '0);

    always_ff @(posedge sys_clk_i) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            d_out     <= '0;
            r_led_cnt <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_ferr <= w_ferr_set | (r_ferr & !w_stat);
            r_ovr  <= w_ovr_set | (r_ovr & !w_stat);
            if (w_rd) d_out <= (addr == 2'd0) ? (w_empty ? 16'h0000 : {8'h00, w_head})
                             : (addr == 2'd1) ? w_status : 16'h0000;
            if (w_wr) r_led_cnt <= LW'(LED_HOLD);
            else if (rx_led) r_led_cnt <= r_led_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed frames against a queue-based receiver model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int BIT   = 160;

    logic        clk, rst, rx_line, cs, rd;
    logic [1:0]  addr;
    logic [15:0] d_out;
    logic        rx_avail, rx_led;

    logic [7:0]  q[$];
    logic        m_ferr, m_ovr, settled;
    logic [15:0] exp_d;
    int          n_chk, n_pass, lat;

    uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(10_000), .DEPTH(DEPTH), .LED_HOLD(50)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .uart_rx(rx_line), .cs(cs), .rd(rd),
        .addr(addr), .d_out(d_out), .rx_avail(rx_avail), .rx_led(rx_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("d_out", {16'h0, d_out}, {16'h0, exp_d});
            if (settled) chk("rx_avail", {31'h0, rx_avail}, {31'h0, q.size() != 0});
        end
    end

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        settled = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_line = f[i];
            repeat (per - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_line = 1'b1;
        if (!stop_ok) m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
        settled = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic use_lit, input logic [15:0] lit);
        @(negedge clk);
        cs = 1'b1;
        rd = 1'b1;
        addr = a;
        if (a == 2'd0) exp_d = (q.size() != 0) ? {8'h00, q.pop_front()} : 16'h0000;
        else if (a == 2'd1) begin
            exp_d = {12'h000, m_ferr, m_ovr, q.size() == DEPTH, q.size() != 0};
            m_ferr = 1'b0;
            m_ovr = 1'b0;
        end else exp_d = 16'h0000;
        @(posedge clk);
        #1;
        if (use_lit) chk("read_literal", {16'h0, d_out}, {16'h0, lit});
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
    endtask

    task automatic measure_latency();
        int n, led;
        @(negedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rx_avail && n < 3000);
        n_chk++;
        if (rx_avail && n >= 1511 && n <= 1536) n_pass++;
        else $display("FAIL latency: got %0d cycles (avail=%0b), required 1511..1536", n, rx_avail);
        if (rx_avail) lat = n;
        led = 0;
        while (rx_led && led < 200) begin
            led++;
            @(posedge clk);
            #1;
        end
        chk("led_width", led, 50);
    endtask

    task automatic push_at_edge_read(input logic [7:0] b, input logic [1:0] a, input logic [15:0] lit);
        fork
            send_frame(b, BIT, 1'b1);
            begin
                @(negedge clk);
                repeat (lat - 1) @(posedge clk);
                bus_read(a, 1'b1, lit);
            end
        join
    endtask

    initial begin
        n_chk = 0; n_pass = 0; lat = 1533;
        rst = 1'b1; rx_line = 1'b1; cs = 1'b0; rd = 1'b0; addr = 2'd0;
        m_ferr = 1'b0; m_ovr = 1'b0; exp_d = 16'h0000; settled = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_d_out", {16'h0, d_out}, 32'h0);
        chk("reset_avail", {31'h0, rx_avail}, 32'h0);
        chk("reset_led", {31'h0, rx_led}, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        settled = 1'b1;
        fork
            send_frame(8'hA5, BIT, 1'b1);
            measure_latency();
        join
        bus_read(2'd1, 1'b1, 16'h0001);
        bus_read(2'd0, 1'b1, 16'h00A5);
        chk("avail_after_pop", {31'h0, rx_avail}, 32'h0);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (30) @(negedge clk);
        rx_line = 1'b1;
        repeat (400) @(negedge clk);
        bus_read(2'd1, 1'b1, 16'h0000);
        send_frame(8'h3C, BIT, 1'b0);
        repeat (50) @(negedge clk);
        bus_read(2'd1, 1'b1, 16'h0008);
        bus_read(2'd1, 1'b1, 16'h0000);
        send_frame(8'h11, BIT, 1'b1);
        bus_read(2'd0, 1'b1, 16'h0011);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), BIT, 1'b1);
        bus_read(2'd1, 1'b1, 16'h0007);
        for (int i = 1; i <= 4; i++) bus_read(2'd0, 1'b1, 16'(i));
        bus_read(2'd0, 1'b1, 16'h0000);
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), BIT, 1'b1);
        push_at_edge_read(8'h14, 2'd0, 16'h0010);
        bus_read(2'd1, 1'b1, 16'h0003);
        for (int i = 1; i <= 4; i++) bus_read(2'd0, 1'b1, 16'h0010 + 16'(i));
        for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), BIT, 1'b1);
        push_at_edge_read(8'h24, 2'd1, 16'h0003);
        bus_read(2'd1, 1'b1, 16'h0007);
        bus_read(2'd1, 1'b1, 16'h0003);
        for (int i = 0; i < 4; i++) bus_read(2'd0, 1'b1, 16'h0020 + 16'(i));
        send_frame(8'h77, BIT, 1'b1);
        bus_read(2'd1, 1'b1, 16'h0001);
        settled = 1'b0;
        @(negedge clk);
        rx_line = 1'b0;
        repeat (BIT) @(negedge clk);
        rx_line = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        exp_d = 16'h0000;
        #1;
        chk("async_reset_d_out", {16'h0, d_out}, 32'h0);
        chk("async_reset_avail", {31'h0, rx_avail}, 32'h0);
        chk("async_reset_led", {31'h0, rx_led}, 32'h0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4 * BIT) @(negedge clk);
        settled = 1'b1;
        send_frame(8'h42, BIT, 1'b1);
        bus_read(2'd0, 1'b1, 16'h0042);
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                send_frame(8'($urandom), int'($urandom_range(156, 164)), $urandom_range(0, 7) != 0);
                repeat ($urandom_range(1, 100)) @(negedge clk);
            end else bus_read(2'($urandom_range(0, 3)), 1'b0, 16'h0000);
        end
        bus_read(2'd1, 1'b0, 16'h0000);
        while (q.size() != 0) bus_read(2'd0, 1'b0, 16'h0000);
        bus_read(2'd0, 1'b1, 16'h0000);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
